// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared LCD geometry defaults, RGB565 colours and scheduler FSM encoding
package lcd_pkg;

    // Default panel geometry (st7735 landscape, 160x80)
    localparam int LCD_WIDTH  = 160;
    localparam int LCD_HEIGHT = 80;

    // RGB565 colour constants
    localparam logic [15:0] RGB_BLACK = 16'h0000;
    localparam logic [15:0] RGB_RED   = 16'hF800;
    localparam logic [15:0] RGB_GREEN = 16'h07E0;
    localparam logic [15:0] RGB_BLUE  = 16'h001F;

    // Scheduler FSM encoding; NEXT is a decision taken inside the SHOW fb cycle,
    // so it has no code of its own
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHOW  = 2'd1;
    localparam logic [1:0] ST_BLANK = 2'd2;

endpackage

// File: rtl/lcd_frame_tracker.sv
// rtl/lcd_frame_tracker.sv - frame boundary detect and registered frame_done pulse
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   x, y          current pixel position from the driver
//   next_pixel    1-clk strobe: pixel (x,y) consumed
//   fb            combinational frame boundary (last pixel of the frame consumed)
//   frame_done    fb delayed by one clock
module lcd_frame_tracker #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic       next_pixel,
    output logic       fb,
    output logic       frame_done
);

    // Out-of-range coordinates can never match, so they never produce an fb
    assign fb = next_pixel && (x == 8'(WIDTH - 1)) && (y == 7'(HEIGHT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= fb;
        end
    end

endmodule

// File: rtl/lcd_frame_scheduler.sv
// rtl/lcd_frame_scheduler.sv - frame-synchronous RGB565 pattern scheduler for the st7735 driver
//
// Optional feature macro: LCD_SCHED_BLANK_EN (insert one black frame between patterns).
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   enable         run the scheduler; acted on only at frame boundaries
//   x, y           current pixel position from the driver
//   next_pixel     1-clk strobe: pixel (x,y) consumed
//   pat_color      flat RGB565 sources, source k at [16k+15:16k]
//   dwell_frames   frames per pattern (0 behaves as 1), sampled at reload
//   color          registered RGB565 to the driver
//   pat_sel        index of the active pattern
//   frame_done     1-clk pulse after every frame boundary
//   busy           high while showing or blanking
module lcd_frame_scheduler
    import lcd_pkg::*;
#(
    parameter int NUM_PAT = 4,
    parameter int DWELL_W = 8,
    parameter int WIDTH   = LCD_WIDTH,
    parameter int HEIGHT  = LCD_HEIGHT,
    localparam int PSEL_W = $clog2(NUM_PAT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [7:0]            x,
    input  logic [6:0]            y,
    input  logic                  next_pixel,
    input  logic [16*NUM_PAT-1:0] pat_color,
    input  logic [DWELL_W-1:0]    dwell_frames,
    output logic [15:0]           color,
    output logic [PSEL_W-1:0]     pat_sel,
    output logic                  frame_done,
    output logic                  busy
);

    logic [1:0]         state;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_load;
    logic [PSEL_W-1:0]  pat_next;
    logic [15:0]        pat_mux;
    logic               fb;

    lcd_frame_tracker #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .x          (x),
        .y          (y),
        .next_pixel (next_pixel),
        .fb         (fb),
        .frame_done (frame_done)
    );

    assign dwell_load = (dwell_frames == '0) ? DWELL_W'(1) : dwell_frames;

    // Explicit compare so non-power-of-2 pattern counts wrap correctly
    assign pat_next = (pat_sel == PSEL_W'(NUM_PAT - 1)) ? '0 : pat_sel + PSEL_W'(1);

    assign busy = (state != ST_IDLE);

    always_comb begin
        pat_mux = RGB_BLACK;
        for (int k = 0; k < NUM_PAT; k++) begin
            if (pat_sel == PSEL_W'(k)) begin
                pat_mux = pat_color[16*k +: 16];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            color     <= RGB_BLACK;
            pat_sel   <= '0;
            dwell_cnt <= '0;
        end else begin
            color <= (state == ST_SHOW) ? pat_mux : RGB_BLACK;
            if (fb) begin
                case (state)
                    ST_IDLE: begin
                        if (enable) begin
                            state     <= ST_SHOW;
                            dwell_cnt <= dwell_load;
                        end
                    end
                    ST_SHOW: begin
                        // A count of 0 is treated as the last frame so it can never wrap
                        if (dwell_cnt > DWELL_W'(1)) begin
                            dwell_cnt <= dwell_cnt - DWELL_W'(1);
                        end else begin
                            dwell_cnt <= '0;
                            if (!enable) begin
                                state <= ST_IDLE;
                            end else begin
                                pat_sel <= pat_next;
`ifdef LCD_SCHED_BLANK_EN
                                state <= ST_BLANK;
`else
                                dwell_cnt <= dwell_load;
`endif
                            end
                        end
                    end
`ifdef LCD_SCHED_BLANK_EN
                    ST_BLANK: begin
                        if (enable) begin
                            state     <= ST_SHOW;
                            dwell_cnt <= dwell_load;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
`endif
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// tb/tb_lcd_frame_scheduler.sv - randomized self-checking bench for lcd_frame_scheduler
module tb_lcd_frame_scheduler;

    localparam int NP = 4;
    localparam int DW = 8;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int FP = W * H;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b1;
    logic [7:0]     x = '0;
    logic [6:0]     y = '0;
    logic           next_pixel = 1'b0;
    logic [16*NP-1:0] pat_color = '0;
    logic [DW-1:0]  dwell_frames = '0;
    logic [15:0]    color;
    logic [1:0]     pat_sel;
    logic           frame_done;
    logic           busy;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Frame-level reference: running flag, shown pattern, frames left, blank frame pending
    int m_run   = 0;
    int m_pat   = 0;
    int m_left  = 0;
    int m_blank = 0;
    int cur_idx = 0;

    always #5 clk = ~clk;

    lcd_frame_scheduler #(
        .NUM_PAT (NP),
        .DWELL_W (DW),
        .WIDTH   (W),
        .HEIGHT  (H)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .x            (x),
        .y            (y),
        .next_pixel   (next_pixel),
        .pat_color    (pat_color),
        .dwell_frames (dwell_frames),
        .color        (color),
        .pat_sel      (pat_sel),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        chk_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int dwell_of(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    // One completed frame: decide what the next frame shows
    task automatic model_frame_end(input int en, input int dw);
        if (m_run == 0) begin
            if (en != 0) begin
                m_run  = 1;
                m_left = dwell_of(dw);
            end
        end else if (m_blank != 0) begin
            m_blank = 0;
            if (en != 0) m_left = dwell_of(dw);
            else m_run = 0;
        end else if (m_left > 1) begin
            m_left = m_left - 1;
        end else if (en == 0) begin
            m_run = 0;
        end else begin
            m_pat = (m_pat + 1) % NP;
`ifdef LCD_SCHED_BLANK_EN
            m_blank = 1;
`else
            m_left = dwell_of(dw);
`endif
        end
    endtask

    task automatic tick();
        logic [15:0] ec;
        logic fbs;
        int ens, dws;
        logic rs;
        ec  = (m_run != 0 && m_blank == 0) ? pat_color[16*m_pat +: 16] : 16'h0000;
        fbs = next_pixel && (x == W - 1) && (y == H - 1);
        ens = int'(enable);
        dws = int'(dwell_frames);
        rs  = rst_n;
        @(posedge clk);
        #1;
        if (!rs) begin
            m_run = 0; m_pat = 0; m_left = 0; m_blank = 0;
            ec = 16'h0000;
            fbs = 1'b0;
        end else if (fbs) begin
            model_frame_end(ens, dws);
        end
        check("color", color, ec);
        check("pat_sel", pat_sel, m_pat);
        check("busy", busy, m_run);
        check("frame_done", frame_done, fbs);
    endtask

    task automatic pixel(input int px, input int py);
        x = 8'(px);
        y = 7'(py);
        next_pixel = 1'b0;
        pat_color = {$urandom, $urandom};
        repeat ($urandom_range(1, 2)) tick();
        next_pixel = 1'b1;
        tick();
        next_pixel = 1'b0;
    endtask

    task automatic run(input int npix);
        for (int i = 0; i < npix; i++) begin
            pixel(cur_idx % W, cur_idx / W);
            cur_idx = (cur_idx + 1) % FP;
        end
    endtask

    task automatic run_to_start();
        if (cur_idx != 0) run(FP - cur_idx);
    endtask

    initial begin
        int saved;
        int found;

        // 1: reset held with enable high
        rst_n = 1'b0;
        enable = 1'b1;
        repeat (3) tick();
        check("rst_color", color, 0);
        check("rst_pat_sel", pat_sel, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        // 2: enable mid-frame, dwell 2
        dwell_frames = 8'd2;
        cur_idx = 5;
        run(FP - 5 - 1);
        check("t2_idle_before_fb", busy, 0);
        run(1);
        check("t2_show_after_fb", busy, 1);
        run(2 * FP);
        check("t2_step", pat_sel, 1);
        run(6 * FP);
`ifndef LCD_SCHED_BLANK_EN
        check("t2_wrap", pat_sel, 0);
`endif

        // 3: dwell 0 acts as 1, then a mid-dwell change is deferred
        dwell_frames = 8'd0;
        run(4 * FP);
        dwell_frames = 8'd5;
        found = 0;
        for (int f = 0; f < 12 && found == 0; f++) begin
            run_to_start();
            if (m_run != 0 && m_blank == 0 && m_left == 5) found = 1;
            else run(1);
        end
        check("t3_align", found, 1);
        saved = int'(pat_sel);
        run(2 * FP);
        dwell_frames = 8'd1;
        run(3 * FP - 1);
        check("t3_hold", pat_sel, saved);
        run(1);
        check("t3_adv", pat_sel, (saved + 1) % NP);

        // 4: enable drops at pixel (4,2) of frame 1 of a 3-frame dwell
        dwell_frames = 8'd3;
        found = 0;
        for (int f = 0; f < 12 && found == 0; f++) begin
            run_to_start();
            if (m_run != 0 && m_blank == 0 && m_left == 3) found = 1;
            else run(1);
        end
        check("t4_align", found, 1);
        saved = int'(pat_sel);
        run(2 * W + 4);
        enable = 1'b0;
        run(FP - (2 * W + 4) + FP);
        check("t4_busy_hold", busy, 1);
        run(FP);
        tick();
        check("t4_exit_busy", busy, 0);
        check("t4_exit_color", color, 0);
        check("t4_exit_pat", pat_sel, saved);

        // 5: dwell 1, consecutive frames step through patterns
        dwell_frames = 8'd1;
        enable = 1'b1;
        run(5 * FP);

        // 6: reset mid-show with pattern 2
        found = 0;
        for (int f = 0; f < 12 && found == 0; f++) begin
            run_to_start();
            if (m_run != 0 && m_blank == 0 && m_pat == 2) found = 1;
            else run(1);
        end
        check("t6_align", found, 1);
        run(10);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_pat", pat_sel, 0);
        check("t6_busy", busy, 0);
        check("t6_color", color, 0);
        run_to_start();
        check("t6_recover", busy, 1);

        // Randomized phase
        for (int i = 0; i < 40 * FP; i++) begin
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            if ($urandom_range(0, 59) == 0) dwell_frames = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) pixel($urandom_range(W, 255), H - 1);
            if ($urandom_range(0, 49) == 0) pixel(W - 1, $urandom_range(H, 127));
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            run(1);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
